// File: rtl/tpu_pkg.sv
// ---------------------------------------------------------------------------
// tpu_pkg
// Shared definitions for the systolic MAC array and its weight loader.
//   WEIGHT_W       : width of one weight lane (one per array column)
//   ACC_W          : MAC accumulator width
//   loader_state_t : weight loader FSM states
// ---------------------------------------------------------------------------
package tpu_pkg;

    localparam int WEIGHT_W = 8;
    localparam int ACC_W    = 32;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        PAD   = 2'd1,
        ARMED = 2'd2
    } loader_state_t;

endpackage : tpu_pkg

// File: rtl/weight_loader.sv
// ---------------------------------------------------------------------------
// weight_loader
// Upstream feeder for one systolic MAC array. Accepts a weight tile one row
// per beat, shifts it into the array's shadow weight buffers through the
// per-column weight_in / load_weight chain, then issues a single-cycle
// swap_weights pulse once the array controller allows it. The next tile can
// be preloaded while the array computes on the active one.
//
// Rows arrive bottom-first: beat 0 ends up in MAC row ROWS-1.
//
// Ports:
//   clk          clock
//   rst          asynchronous reset, active-high
//   s_valid      weight row beat valid
//   s_ready      loader accepts a beat this cycle
//   s_data       one weight row, lane c = bits [8c+7:8c] feeds column c
//   s_last       final beat of a short tile (optional feature only)
//   swap_ok      array controller permits a buffer swap this cycle
//   weight_in    to the top-row MAC weight_in of each column
//   load_weight  shared shift strobe to all MACs
//   swap_weights shared one-cycle swap strobe to all MACs
//   armed        full tile shifted in, waiting for swap_ok
//   tile_count   swaps issued since reset, wraps modulo 2^CNT_W
//
// Build option:
//   WEIGHT_LOADER_SHORT_TILE_EN - when defined, s_last on beat k < ROWS-1
//   ends the tile early and the loader pads the remaining ROWS-1-k rows with
//   zero weights. When undefined, s_last is ignored and every tile is ROWS
//   beats long.
// ---------------------------------------------------------------------------
module weight_loader
    import tpu_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [COLS*WEIGHT_W-1:0] s_data,
    input  logic                     s_last,
    input  logic                     swap_ok,
    output logic [COLS*WEIGHT_W-1:0] weight_in,
    output logic                     load_weight,
    output logic                     swap_weights,
    output logic                     armed,
    output logic [CNT_W-1:0]         tile_count
);

    localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [RC_W-1:0] LAST_ROW = RC_W'(ROWS - 1);

    loader_state_t   state;
    logic [RC_W-1:0] row_cnt;
    logic            accept;

    // Ready is a pure decode of the state register; rst forces it low while
    // asserted so no beat can be taken during reset.
    assign s_ready = (state == LOAD) & ~rst;
    assign accept  = s_valid & s_ready;

`ifndef WEIGHT_LOADER_SHORT_TILE_EN
    logic unused_s_last;
    assign unused_s_last = s_last;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= LOAD;
            row_cnt      <= '0;
            weight_in    <= '0;
            load_weight  <= 1'b0;
            swap_weights <= 1'b0;
            armed        <= 1'b0;
            tile_count   <= '0;
        end else begin
            // Strobes default low; weight_in holds so the MAC chain holds.
            load_weight  <= 1'b0;
            swap_weights <= 1'b0;

            case (state)
                LOAD: begin
                    if (accept) begin
                        weight_in   <= s_data;
                        load_weight <= 1'b1;
                        if (row_cnt == LAST_ROW) begin
                            state   <= ARMED;
                            armed   <= 1'b1;
                            row_cnt <= '0;
                        end
`ifdef WEIGHT_LOADER_SHORT_TILE_EN
                        else if (s_last) begin
                            state   <= PAD;
                            row_cnt <= row_cnt + 1'b1;
                        end
`endif
                        else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end

`ifdef WEIGHT_LOADER_SHORT_TILE_EN
                // Push zero rows until the chain has seen ROWS shifts, so the
                // unused top rows carry weight 0.
                PAD: begin
                    weight_in   <= '0;
                    load_weight <= 1'b1;
                    if (row_cnt == LAST_ROW) begin
                        state   <= ARMED;
                        armed   <= 1'b1;
                        row_cnt <= '0;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
`endif

                // Entry into ARMED happens on the edge that registers the last
                // load, so the earliest swap lands one cycle after that load.
                ARMED: begin
                    if (swap_ok) begin
                        swap_weights <= 1'b1;
                        tile_count   <= tile_count + 1'b1;
                        armed        <= 1'b0;
                        state        <= LOAD;
                    end
                end

                default: begin
                    state   <= LOAD;
                    row_cnt <= '0;
                    armed   <= 1'b0;
                end
            endcase
        end
    end

endmodule : weight_loader

// File: tb/tb_weight_loader.sv
// ---------------------------------------------------------------------------
// tb_weight_loader
// Directed bench for weight_loader (ROWS=4, COLS=4, CNT_W=2 so the tile
// counter wraps within a short run). A small model of the array's shadow and
// active weight registers follows load_weight / swap_weights so the final
// contents of the array can be compared against the hand-written tiles.
// ---------------------------------------------------------------------------
module tb_weight_loader;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int CNT_W = 2;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [COLS*8-1:0] s_data;
    logic              s_last;
    logic              swap_ok;
    logic [COLS*8-1:0] weight_in;
    logic              load_weight;
    logic              swap_weights;
    logic              armed;
    logic [CNT_W-1:0]  tile_count;

    int n_tests = 0;
    int n_fail  = 0;

    weight_loader #(
        .ROWS (ROWS),
        .COLS (COLS),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .swap_ok     (swap_ok),
        .weight_in   (weight_in),
        .load_weight (load_weight),
        .swap_weights(swap_weights),
        .armed       (armed),
        .tile_count  (tile_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: row 0 is the top row fed by weight_in.
    logic [COLS*8-1:0] shadow [ROWS];
    logic [COLS*8-1:0] active [ROWS];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROWS; r++) begin
                shadow[r] <= '0;
                active[r] <= '0;
            end
        end else begin
            if (load_weight) begin
                shadow[0] <= weight_in;
                for (int r = 1; r < ROWS; r++) shadow[r] <= shadow[r-1];
            end
            if (swap_weights) begin
                for (int r = 0; r < ROWS; r++) active[r] <= shadow[r];
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one beat and check it appears on the chain in the next cycle.
    task automatic beat(input string tag, input logic [31:0] d, input logic last);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        tick();
        chk({tag, "_load"}, 64'(load_weight), 64'd1);
        chk({tag, "_win"},  64'(weight_in),   64'(d));
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 32'hDEAD_BEEF;
    endtask

    task automatic chk_active(input string tag, input logic [31:0] r3, input logic [31:0] r2,
                              input logic [31:0] r1, input logic [31:0] r0);
        chk({tag, "_r3"}, 64'(active[3]), 64'(r3));
        chk({tag, "_r2"}, 64'(active[2]), 64'(r2));
        chk({tag, "_r1"}, 64'(active[1]), 64'(r1));
        chk({tag, "_r0"}, 64'(active[0]), 64'(r0));
    endtask

    initial begin
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        swap_ok = 1'b0;

        // ---- reset state ----
        #2;
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_load",  64'(load_weight), 64'd0);
        chk("rst_swap",  64'(swap_weights), 64'd0);
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_win",   64'(weight_in), 64'd0);
        chk("rst_cnt",   64'(tile_count), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(s_ready), 64'd1);

        // ---- tile 1: back-to-back beats, swap_ok low ----
        beat("t1b0", 32'h04030201, 1'b0);
        chk("t1b0_armed", 64'(armed), 64'd0);
        beat("t1b1", 32'h08070605, 1'b0);
        beat("t1b2", 32'h0C0B0A09, 1'b0);
        chk("t1b2_armed", 64'(armed), 64'd0);
        beat("t1b3", 32'h100F0E0D, 1'b0);
        chk("t1_armed",  64'(armed), 64'd1);
        chk("t1_ready",  64'(s_ready), 64'd0);
        chk("t1_swap",   64'(swap_weights), 64'd0);
        tick();
        chk("t1_hold_load", 64'(load_weight), 64'd0);
        chk("t1_hold_win",  64'(weight_in), 64'h100F0E0D);
        chk("t1_hold_swap", 64'(swap_weights), 64'd0);
        tick();
        chk("t1_wait_armed", 64'(armed), 64'd1);
        chk("t1_wait_swap",  64'(swap_weights), 64'd0);

        swap_ok = 1'b1;
        tick();
        swap_ok = 1'b0;
        chk("t1_swap_pulse", 64'(swap_weights), 64'd1);
        chk("t1_cnt",        64'(tile_count), 64'd1);
        chk("t1_unarmed",    64'(armed), 64'd0);
        chk("t1_ready_back", 64'(s_ready), 64'd1);
        tick();
        chk("t1_swap_once",  64'(swap_weights), 64'd0);
        chk_active("t1_act", 32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D);

        // ---- tile 2: 1, 2, 3 idle cycles between beats ----
        beat("t2b0", 32'hA1A2A3A4, 1'b0);
        tick();
        chk("t2g0_load", 64'(load_weight), 64'd0);
        chk("t2g0_win",  64'(weight_in), 64'hA1A2A3A4);
        beat("t2b1", 32'hB1B2B3B4, 1'b0);
        for (int g = 0; g < 2; g++) begin
            tick();
            chk("t2g1_load", 64'(load_weight), 64'd0);
            chk("t2g1_win",  64'(weight_in), 64'hB1B2B3B4);
        end
        beat("t2b2", 32'hC1C2C3C4, 1'b0);
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("t2g2_load", 64'(load_weight), 64'd0);
            chk("t2g2_win",  64'(weight_in), 64'hC1C2C3C4);
            chk("t2g2_armed", 64'(armed), 64'd0);
        end
        beat("t2b3", 32'hD1D2D3D4, 1'b0);
        chk("t2_armed", 64'(armed), 64'd1);
        swap_ok = 1'b1;
        tick();
        swap_ok = 1'b0;
        chk("t2_swap", 64'(swap_weights), 64'd1);
        chk("t2_cnt",  64'(tile_count), 64'd2);
        tick();
        chk_active("t2_act", 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4);

        // ---- tiles 3..5: swap_ok held high throughout, counter wraps ----
        swap_ok = 1'b1;
        for (int t = 0; t < 3; t++) begin
            for (int b = 0; b < ROWS; b++) begin
                beat("t345", 32'h1000_0000 * (t + 1) + 32'(b), 1'b0);
                chk("t345_noswap", 64'(swap_weights), 64'd0);
            end
            chk("t345_armed", 64'(armed), 64'd1);
            tick();
            chk("t345_swap", 64'(swap_weights), 64'd1);
            chk("t345_cnt",  64'(tile_count), 64'((3 + t) % 4));
        end
        tick();
        chk("t345_no_repeat", 64'(swap_weights), 64'd0);
        chk("t345_idle_ready", 64'(s_ready), 64'd1);
        swap_ok = 1'b0;
        chk_active("t5_act", 32'h30000000, 32'h30000001, 32'h30000002, 32'h30000003);

        // ---- reset in the middle of a tile ----
        beat("r_b0", 32'h55555555, 1'b0);
        beat("r_b1", 32'h66666666, 1'b0);
        rst = 1'b1;
        #1;
        chk("r_load",  64'(load_weight), 64'd0);
        chk("r_win",   64'(weight_in), 64'd0);
        chk("r_ready", 64'(s_ready), 64'd0);
        chk("r_cnt",   64'(tile_count), 64'd0);
        chk("r_armed", 64'(armed), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("r_ready_back", 64'(s_ready), 64'd1);
        beat("r_b0n", 32'h0000_0011, 1'b0);
        beat("r_b1n", 32'h0000_0022, 1'b0);
        beat("r_b2n", 32'h0000_0033, 1'b0);
        chk("r_not_armed", 64'(armed), 64'd0);
        beat("r_b3n", 32'h0000_0044, 1'b0);
        chk("r_armed_n", 64'(armed), 64'd1);
        swap_ok = 1'b1;
        tick();
        swap_ok = 1'b0;
        chk("r_swap", 64'(swap_weights), 64'd1);
        chk("r_cnt1", 64'(tile_count), 64'd1);
        tick();
        chk_active("r_act", 32'h11, 32'h22, 32'h33, 32'h44);

        // ---- short tile: two beats, s_last on the second ----
        beat("s_b0", 32'hEEEE0001, 1'b0);
        beat("s_b1", 32'hEEEE0002, 1'b1);
`ifdef WEIGHT_LOADER_SHORT_TILE_EN
        chk("s_ready_pad", 64'(s_ready), 64'd0);
        tick();
        chk("s_pad0_load", 64'(load_weight), 64'd1);
        chk("s_pad0_win",  64'(weight_in), 64'd0);
        chk("s_pad0_armed", 64'(armed), 64'd0);
        tick();
        chk("s_pad1_load", 64'(load_weight), 64'd1);
        chk("s_pad1_win",  64'(weight_in), 64'd0);
        chk("s_pad1_armed", 64'(armed), 64'd1);
        tick();
        chk("s_after_load", 64'(load_weight), 64'd0);
        swap_ok = 1'b1;
        tick();
        swap_ok = 1'b0;
        chk("s_swap", 64'(swap_weights), 64'd1);
        tick();
        chk_active("s_act", 32'hEEEE0001, 32'hEEEE0002, 32'h0, 32'h0);
`else
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("s_wait_armed", 64'(armed), 64'd0);
            chk("s_wait_ready", 64'(s_ready), 64'd1);
            chk("s_wait_load",  64'(load_weight), 64'd0);
        end
        beat("s_b2", 32'hEEEE0003, 1'b0);
        chk("s_b2_armed", 64'(armed), 64'd0);
        beat("s_b3", 32'hEEEE0004, 1'b0);
        chk("s_armed", 64'(armed), 64'd1);
        swap_ok = 1'b1;
        tick();
        swap_ok = 1'b0;
        chk("s_swap", 64'(swap_weights), 64'd1);
        tick();
        chk_active("s_act", 32'hEEEE0001, 32'hEEEE0002, 32'hEEEE0003, 32'hEEEE0004);
`endif
        chk("s_cnt", 64'(tile_count), 64'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_weight_loader
